spi_master_tx_multi: RTL and testbench
======================================

SPI_MASTER_TX_MULTI -- requirements
Module: spi_master_tx_multi

Parameters
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; it must be a multiple of 4 and at least 8.
REQ-002 SHALL have parameter CNT_W, default 16, width of the transfer-length counter.

Interface
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  transfer enable from the controller.
REQ-006 tx_edge  in  1  one-cycle strobe marking the SPI shift edge.
REQ-007 mode  in  2  lane mode: 00 single, 01 dual, 10 quad, 11 treated as single.
REQ-008 msb_first  in  1  bit order: 1 MSB-first, 0 LSB-first.
REQ-009 counter_in  in  CNT_W  transfer length in bits.
REQ-010 counter_in_upd  in  1  load strobe for counter_in.
REQ-011 data  in  DATA_W  next word to transmit.
REQ-012 data_valid  in  1  data holds a valid word.
REQ-013 data_ready  out  1  one-cycle pulse when data is consumed.
REQ-014 sdo  out  4  serial data lanes.
REQ-015 tx_done  out  1  one-cycle pulse on the final beat of a transfer.
REQ-016 underrun  out  1  one-cycle pulse when a word refill found data_valid low.
REQ-017 clk_en_o  out  1  SPI clock enable.

Function
REQ-018 Lane count L SHALL be 1, 2 or 4 per the active mode; beats per word WB SHALL equal DATA_W/L.
REQ-019 On counter_in_upd the pending target SHALL latch counter_in >> log2(L), where L is taken from the mode input in that cycle.
REQ-020 The pending target SHALL be copied into the active target, and mode/msb_first into active copies, only on the IDLE->TRANSMIT transition; counter_in_upd during TRANSMIT SHALL NOT affect the running transfer.
REQ-021 States SHALL be IDLE and TRANSMIT.
REQ-022 IDLE->TRANSMIT SHALL occur when en && data_valid && pending target != 0; in that cycle data_ready=1 and the shift register loads data.
REQ-023 With a pending target of 0 the block SHALL remain in IDLE with data_ready=0.
REQ-024 clk_en_o SHALL be 1 in TRANSMIT, except 0 in the cycle that decides to return to IDLE.
REQ-025 On each tx_edge in TRANSMIT: beat_cnt SHALL increment, word_cnt SHALL increment (wrapping at WB), and the shift register SHALL shift by L toward the output end.
REQ-026 In MSB-first order lane i SHALL drive sh[DATA_W-L+i]; in LSB-first order lane i SHALL drive sh[i]. Lanes i>=L SHALL drive 0, and shifting SHALL be toward the output end.
REQ-027 tx_done SHALL be combinational: tx_edge && TRANSMIT && beat_cnt == active_target-1.
REQ-028 On tx_done, beat_cnt and word_cnt SHALL clear. If en && data_valid, the block reloads data with data_ready=1, re-copies target/mode and stays in TRANSMIT; otherwise it goes to IDLE.
REQ-029 On tx_edge with word_cnt == WB-1 and no tx_done: if data_valid, the block reloads with data_ready=1; otherwise underrun=1, clk_en_o=0 and the next state is IDLE.
REQ-030 tx_done SHALL take priority over a simultaneous word-boundary refill.
REQ-031 tx_edge outside TRANSMIT SHALL be ignored.
REQ-032 Counter arithmetic SHALL be CNT_W-bit unsigned; beat_cnt SHALL never exceed active_target-1.

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE, beat_cnt=0, word_cnt=0, shift register=0, pending and active target=8, active mode=single, active msb_first=1.
REQ-034 While in reset, outputs SHALL be: sdo=0, data_ready=0, tx_done=0, underrun=0, clk_en_o=0.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer within one clock edge, with no tx_done or underrun pulse.

Verification
REQ-036 Single mode, MSB-first, counter_in=8, data=0xA5000000 -> sdo[0] sequence 1,0,1,0,0,1,0,1 over 8 tx_edges; tx_done on the 8th edge; then IDLE.
REQ-037 Quad mode, counter_in=64, two valid words 0x12345678 and 0x9ABCDEF0 -> nibbles 1..8 then 9..0 on sdo; data_ready pulses at start and at beat 8; tx_done at beat 16.
REQ-038 Dual mode, LSB-first, counter_in=64, data_valid dropped after the first word -> underrun pulse at beat 16; clk_en_o=0 in that cycle; no tx_done.
REQ-039 counter_in_upd with a new length during TRANSMIT -> the current transfer uses the old target; the next transfer uses the new one.
REQ-040 counter_in=0 with en && data_valid -> block stays in IDLE and data_ready is never asserted.
REQ-041 rst pulsed at beat 5 of a single-mode transfer -> all outputs 0 on the next cycle; no done or underrun pulse.

Source files
------------

// File: rtl/spi_master_tx_multi_if.sv
// Controller-side bus of the multi-lane SPI transmit engine.
// The master modport is the controller; the slave modport is the shifter.
interface spi_master_tx_multi_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
);
   logic              en;
   logic              tx_edge;
   logic [1:0]        mode;
   logic              msb_first;
   logic [CNT_W-1:0]  counter_in;
   logic              counter_in_upd;
   logic [DATA_W-1:0] data;
   logic              data_valid;
   logic              data_ready;
   logic [3:0]        sdo;
   logic              tx_done;
   logic              underrun;
   logic              clk_en_o;

   modport master (
      output en, tx_edge, mode, msb_first, counter_in, counter_in_upd, data, data_valid,
      input  data_ready, sdo, tx_done, underrun, clk_en_o
   );

   modport slave (
      input  en, tx_edge, mode, msb_first, counter_in, counter_in_upd, data, data_valid,
      output data_ready, sdo, tx_done, underrun, clk_en_o
   );
endinterface

// File: rtl/spi_master_tx_multi.sv
// Multi-lane (1/2/4) SPI transmit shifter with word refill, length counting
// and underrun detection. Handshake outputs are decided in the current cycle.
module spi_master_tx_multi #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input logic                  clk,
   input logic                  rst,
   spi_master_tx_multi_if.slave bus
);
   localparam int unsigned WC_W = $clog2(DATA_W) + 1;

   typedef enum logic {S_IDLE = 1'b0, S_TRANSMIT = 1'b1} state_t;

   state_t            r_state, w_state_nxt;
   logic [DATA_W-1:0] r_sh, w_sh_nxt, w_sh_shifted;
   logic [CNT_W-1:0]  r_beat, w_beat_nxt;
   logic [CNT_W-1:0]  r_pend, w_pend_nxt;
   logic [CNT_W-1:0]  r_act, w_act_nxt;
   logic [WC_W-1:0]   r_word, w_word_nxt, w_wb_last;
   logic [1:0]        r_mode, w_mode_nxt;
   logic              r_msb, w_msb_nxt;
   logic              w_load, w_ready, w_done, w_underrun, w_clk_en;
   logic [3:0]        w_sdo;
   logic [2:0]        w_lanes;

   function automatic logic [1:0] lane_lg(input logic [1:0] m);
      case (m)
         2'b01:   return 2'd1;
         2'b10:   return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   assign w_lanes      = 3'(1) << lane_lg(r_mode);
   assign w_wb_last    = WC_W'(DATA_W >> lane_lg(r_mode)) - WC_W'(1);
   assign w_sh_shifted = r_msb ? (r_sh << w_lanes) : (r_sh >> w_lanes);

   // Lane mapping from the output end of the shift register
   always_comb begin
      w_sdo = '0;
      case (r_mode)
         2'b01:   w_sdo[1:0] = r_msb ? r_sh[DATA_W-1 -: 2] : r_sh[1:0];
         2'b10:   w_sdo      = r_msb ? r_sh[DATA_W-1 -: 4] : r_sh[3:0];
         default: w_sdo[0]   = r_msb ? r_sh[DATA_W-1]      : r_sh[0];
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sh_nxt    = r_sh;
      w_beat_nxt  = r_beat;
      w_word_nxt  = r_word;
      w_act_nxt   = r_act;
      w_mode_nxt  = r_mode;
      w_msb_nxt   = r_msb;
      w_load      = 1'b0;
      w_ready     = 1'b0;
      w_done      = 1'b0;
      w_underrun  = 1'b0;
      w_clk_en    = 1'b0;
      w_pend_nxt  = bus.counter_in_upd ? (bus.counter_in >> lane_lg(bus.mode)) : r_pend;

      case (r_state)
         S_IDLE: begin
            if (bus.en && bus.data_valid && (r_pend != '0)) begin
               w_load      = 1'b1;
               w_state_nxt = S_TRANSMIT;
            end
         end
         S_TRANSMIT: begin
            w_clk_en = 1'b1;
            if (bus.tx_edge) begin
               w_sh_nxt   = w_sh_shifted;
               w_beat_nxt = r_beat + CNT_W'(1);
               w_word_nxt = (r_word == w_wb_last) ? '0 : r_word + WC_W'(1);
               // End of transfer wins over a coincident word refill
               if (r_beat == r_act - CNT_W'(1)) begin
                  w_done     = 1'b1;
                  w_beat_nxt = '0;
                  w_word_nxt = '0;
                  if (bus.en && bus.data_valid && (r_pend != '0)) begin
                     w_load = 1'b1;
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_clk_en    = 1'b0;
                  end
               end else if (r_word == w_wb_last) begin
                  if (bus.data_valid) begin
                     w_sh_nxt = bus.data;
                     w_ready  = 1'b1;
                  end else begin
                     w_underrun  = 1'b1;
                     w_clk_en    = 1'b0;
                     w_state_nxt = S_IDLE;
                  end
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Start of a transfer: fresh word, cleared counters, configuration snapshot
      if (w_load) begin
         w_ready    = 1'b1;
         w_sh_nxt   = bus.data;
         w_beat_nxt = '0;
         w_word_nxt = '0;
         w_act_nxt  = r_pend;
         w_mode_nxt = bus.mode;
         w_msb_nxt  = bus.msb_first;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_sh    <= '0;
         r_beat  <= '0;
         r_word  <= '0;
         r_pend  <= CNT_W'(8);
         r_act   <= CNT_W'(8);
         r_mode  <= 2'b00;
         r_msb   <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_sh    <= w_sh_nxt;
         r_beat  <= w_beat_nxt;
         r_word  <= w_word_nxt;
         r_pend  <= w_pend_nxt;
         r_act   <= w_act_nxt;
         r_mode  <= w_mode_nxt;
         r_msb   <= w_msb_nxt;
      end
   end

   assign bus.sdo        = rst ? 4'b0000 : w_sdo;
   assign bus.data_ready = w_ready    & ~rst;
   assign bus.tx_done    = w_done     & ~rst;
   assign bus.underrun   = w_underrun & ~rst;
   assign bus.clk_en_o   = w_clk_en   & ~rst;
endmodule

// File: tb/tb_spi_master_tx_multi.sv
// Randomized bench for spi_master_tx_multi against a per-beat lane/bit model.
module tb_spi_master_tx_multi;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_master_tx_multi_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   spi_master_tx_multi #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_vec = 0;
   int          n_err = 0;
   int          pend_beats = 8;
   bit          chain_pending = 1'b0;
   logic [31:0] chain_w = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lg(input logic [1:0] m);
      return (m == 2'b01) ? 1 : (m == 2'b10) ? 2 : 0;
   endfunction

   // Lane i on beat j of a word: MSB-first walks down from the top, LSB-first up from bit 0
   function automatic logic [3:0] exp_sdo(input logic [31:0] w, input int j, input int l, input bit msb);
      logic [3:0] r;
      r = '0;
      for (int i = 0; i < l; i++) r[i] = msb ? w[32 - l + i - j*l] : w[j*l + i];
      return r;
   endfunction

   task automatic drive_idle();
      bus.en = 1'b0; bus.tx_edge = 1'b0; bus.mode = 2'b00; bus.msb_first = 1'b1;
      bus.counter_in = '0; bus.counter_in_upd = 1'b0; bus.data = '0; bus.data_valid = 1'b0;
   endtask

   task automatic expect_outs(input string tag, input bit chk_sdo, input logic [3:0] es,
                              input bit rdy, input bit dn, input bit ur, input bit ce);
      @(negedge clk);
      if (chk_sdo) check({tag, ".sdo"}, 64'(bus.sdo), 64'(es));
      check({tag, ".data_ready"}, 64'(bus.data_ready), 64'(rdy));
      check({tag, ".tx_done"},    64'(bus.tx_done),    64'(dn));
      check({tag, ".underrun"},   64'(bus.underrun),   64'(ur));
      check({tag, ".clk_en_o"},   64'(bus.clk_en_o),   64'(ce));
      @(posedge clk);
      #1;
   endtask

   task automatic set_len(input logic [1:0] md, input logic [15:0] cnt);
      drive_idle();
      bus.mode = md; bus.counter_in = cnt; bus.counter_in_upd = 1'b1;
      expect_outs("upd", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      pend_beats = int'(cnt) >> lg(md);
   endtask

   function automatic logic [15:0] mk_cnt(input logic [1:0] md);
      int t;
      t = $urandom_range(1, 24);
      return 16'((t << lg(md)) | ($urandom & ((1 << lg(md)) - 1)));
   endfunction

   task automatic transfer(input logic [1:0] md, input bit msb, input logic [31:0] w0,
                           input logic [31:0] w1, input int navail, input bit mid_upd,
                           input logic [1:0] nmd, input bit nmsb, input logic [15:0] ncnt,
                           input bit chain_out, input int abort_k);
      int          l, wb, t, need;
      logic [31:0] words[$];
      bit          last, bnd, avail, urun;
      logic [3:0]  es;
      l = 1 << lg(md); wb = 32 / l; t = pend_beats; need = (t + wb - 1) / wb;
      words.push_back(chain_pending ? chain_w : w0);
      words.push_back(w1);
      while (words.size() < need) words.push_back($urandom);
      if (!chain_pending) begin
         drive_idle();
         bus.en = 1'b1; bus.data_valid = 1'b1; bus.data = words[0]; bus.mode = md; bus.msb_first = msb;
         expect_outs("start", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      chain_pending = 1'b0;
      for (int k = 0; k < t; k++) begin
         last  = (k == t - 1);
         bnd   = ((k % wb) == wb - 1) && !last;
         avail = (k / wb + 1) < navail;
         es    = exp_sdo(words[k / wb], k % wb, l, msb);
         repeat ($urandom_range(0, 2)) begin
            bus.tx_edge = 1'b0; bus.counter_in_upd = 1'b0; bus.en = 1'($urandom);
            bus.data_valid = 1'($urandom); bus.data = $urandom; bus.mode = 2'($urandom);
            bus.msb_first = 1'($urandom);
            expect_outs("gap", 1'b1, es, 1'b0, 1'b0, 1'b0, 1'b1);
         end
         if (k == abort_k) begin
            rst = 1'b1; bus.tx_edge = 1'b1; bus.en = 1'b1; bus.data_valid = 1'b1;
            expect_outs("rst_in", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            rst = 1'b0; drive_idle();
            expect_outs("rst_after", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            pend_beats = 8;
            return;
         end
         bus.tx_edge = 1'b1; bus.en = 1'($urandom); bus.data = $urandom; bus.data_valid = 1'($urandom);
         bus.mode = 2'($urandom); bus.msb_first = 1'($urandom); bus.counter_in_upd = 1'b0;
         if (mid_upd && k == 0) begin
            bus.counter_in_upd = 1'b1; bus.counter_in = ncnt; bus.mode = nmd;
         end
         if (bnd) begin
            bus.data = words[k / wb + 1]; bus.data_valid = avail;
         end
         if (last) begin
            if (chain_out) begin
               bus.en = 1'b1; bus.data_valid = 1'b1; bus.data = $urandom; chain_w = bus.data;
               bus.mode = nmd; bus.msb_first = nmsb;
            end else begin
               bus.data_valid = 1'b0;
            end
         end
         urun = bnd && !avail;
         expect_outs("beat", 1'b1, es, (bnd && avail) || (last && chain_out), last, urun,
                     !(urun || (last && !chain_out)));
         if (mid_upd && k == 0) pend_beats = int'(ncnt) >> lg(nmd);
         if (last && chain_out) chain_pending = 1'b1;
         if (urun) break;
      end
      if (!chain_pending) begin
         drive_idle();
         bus.tx_edge = 1'b1; bus.data_valid = 1'b1;
         expect_outs("idle", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [1:0]  md, nmd;
      bit          msb, nmsb, mid, chn;
      int          need, nav;
      logic [15:0] ncnt;

      drive_idle();
      rst = 1'b1;
      @(posedge clk); #1;
      bus.en = 1'b1; bus.data_valid = 1'b1; bus.tx_edge = 1'b1;
      expect_outs("reset", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_outs("reset", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // Reset-default length of 8, then the explicit single-lane case
      transfer(2'b00, 1'b1, 32'hA500_0000, 32'h0, 1, 1'b0, 2'b00, 1'b1, 16'd0, 1'b0, -1);
      set_len(2'b00, 16'd8);
      transfer(2'b00, 1'b1, 32'hA500_0000, 32'h0, 1, 1'b0, 2'b00, 1'b1, 16'd0, 1'b0, -1);

      set_len(2'b10, 16'd64);
      transfer(2'b10, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 2, 1'b0, 2'b00, 1'b1, 16'd0, 1'b0, -1);

      set_len(2'b01, 16'd64);
      transfer(2'b01, 1'b0, $urandom, $urandom, 1, 1'b0, 2'b00, 1'b1, 16'd0, 1'b0, -1);

      set_len(2'b00, 16'd10);
      transfer(2'b00, 1'b1, $urandom, $urandom, 1, 1'b1, 2'b00, 1'b1, 16'd5, 1'b0, -1);
      transfer(2'b00, 1'b1, $urandom, $urandom, 1, 1'b0, 2'b00, 1'b1, 16'd0, 1'b0, -1);

      set_len(2'b00, 16'd16);
      transfer(2'b00, 1'b1, $urandom, $urandom, 1, 1'b0, 2'b00, 1'b1, 16'd0, 1'b0, 5);

      // Zero-length target, including dual-mode truncation of 1 to 0
      set_len(2'b01, 16'd1);
      repeat (3) begin
         bus.en = 1'b1; bus.data_valid = 1'b1; bus.data = $urandom; bus.tx_edge = 1'($urandom);
         expect_outs("zero_len", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      md = 2'($urandom); msb = 1'($urandom);
      set_len(md, mk_cnt(md));
      for (int i = 0; i < 40; i++) begin
         nmd  = 2'($urandom); nmsb = 1'($urandom); ncnt = mk_cnt(nmd);
         mid  = (pend_beats >= 2) && ($urandom_range(0, 2) == 0);
         chn  = ($urandom_range(0, 2) == 0);
         need = (pend_beats + (32 >> lg(md)) - 1) / (32 >> lg(md));
         nav  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, need) : need;
         transfer(md, msb, $urandom, $urandom, nav, mid, nmd, nmsb, ncnt, chn, -1);
         if (!chain_pending && !mid) set_len(nmd, ncnt);
         md = nmd; msb = nmsb;
      end
      if (chain_pending)
         transfer(md, msb, $urandom, $urandom, 3, 1'b0, 2'b00, 1'b1, 16'd0, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
